// File: rtl/lane_ts_receiver.sv
// ---------------------------------------------------------------------------
// lane_ts_receiver
//
// Receive-side USB4 training-sequence detector. Frames 8-byte TS1/TS2
// ordered sets out of the lane byte stream, validates each one, counts
// consecutive valid sets of the same type and raises sticky detect flags
// for the lane-training FSM.
//
// Ordered set: BC | type (1E=TS1, 2D=TS2) | {6'b0,lane} | payload x4 | xor(1..6)
//
// Optional feature macro: TS_CHECKSUM_EN
//   defined   -> byte 7 is compared against the XOR of bytes 1..6
//   undefined -> byte 7 is consumed and ignored (no checksum logic)
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   enable        : low forces HUNT, clears consecutive counter and flags
//   lane_id       : expected lane number (byte 2)
//   rx_data/valid : received byte stream
//   ts_valid      : 1-cycle pulse, set accepted
//   ts_type       : type of last accepted set (0=TS1, 1=TS2)
//   ts_payload    : bytes 3..6 of last accepted set, byte 3 in [31:24]
//   ts1_det       : sticky, TS1_REQ consecutive TS1 sets seen
//   ts2_det       : sticky, TS2_REQ consecutive TS2 sets seen
//   ts_err        : 1-cycle pulse, set rejected
//   err_cnt       : saturating count of rejected sets
//   dbg_state     : current FSM state (0=HUNT, 1=COLLECT, 2=CHECK)
//
// Handshake: rx_valid is a pure qualifier with no backpressure. Every cycle
// with rx_valid high delivers exactly one byte and that byte is always
// consumed; cycles with rx_valid low change nothing in the framer.
// ---------------------------------------------------------------------------
module lane_ts_receiver #(
  parameter int TS1_REQ = 16,
  parameter int TS2_REQ = 8,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       lane_id,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             ts_valid,
  output logic             ts_type,
  output logic [31:0]      ts_payload,
  output logic             ts1_det,
  output logic             ts2_det,
  output logic             ts_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [7:0] SYNC_BYTE = 8'hBC;
  localparam logic [7:0] TYPE_TS1  = 8'h1E;
  localparam logic [7:0] TYPE_TS2  = 8'h2D;
  localparam int CNT_MAX = (TS1_REQ > TS2_REQ) ? TS1_REQ : TS2_REQ;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q;
  logic [7:0]       type_q;
  logic [7:0]       lane_q;
  logic [31:0]      pay_q;
  logic [CNT_W-1:0] cons_q;

  logic sync_hit;
  logic byte_we;
  logic set_done;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // CHECK behaves like HUNT for the incoming byte so back-to-back sets with
  // no idle between them keep framing.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (sync_hit) state_d = COLLECT;
      COLLECT: if (set_done) state_d = CHECK;
      CHECK:   state_d = sync_hit ? COLLECT : HUNT;
      default: state_d = HUNT;
    endcase
    if (!enable) state_d = HUNT;
  end

  // -------------------------------------------------------------------------
  // FSM: outputs / strobes
  // -------------------------------------------------------------------------
  always_comb begin
    sync_hit  = rx_valid && (rx_data == SYNC_BYTE) &&
                ((state_q == HUNT) || (state_q == CHECK));
    byte_we   = rx_valid && (state_q == COLLECT);
    set_done  = byte_we && (idx_q == 3'd7);
    dbg_state = state_q;
  end

  // -------------------------------------------------------------------------
  // Byte index and set capture. A SYNC byte inside COLLECT is plain data.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= 3'd0;
      type_q <= 8'h00;
      lane_q <= 8'h00;
      pay_q  <= 32'h0;
    end else if (enable) begin
      if (sync_hit) begin
        idx_q <= 3'd1;
      end else if (byte_we) begin
        idx_q <= idx_q + 3'd1;
        case (idx_q)
          3'd1:    type_q        <= rx_data;
          3'd2:    lane_q        <= rx_data;
          3'd3:    pay_q[31:24]  <= rx_data;
          3'd4:    pay_q[23:16]  <= rx_data;
          3'd5:    pay_q[15:8]   <= rx_data;
          3'd6:    pay_q[7:0]    <= rx_data;
          default: ;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Set evaluation. Done on the byte-7 edge so the registered verdict is
  // visible during the CHECK cycle; byte 7 itself is still on rx_data.
  // -------------------------------------------------------------------------
  logic             type_ok;
  logic             is_ts2;
  logic             lane_ok;
  logic             chk_ok;
  logic             set_pass;
  logic [CNT_W-1:0] cons_next;

  always_comb begin
    type_ok = (type_q == TYPE_TS1) || (type_q == TYPE_TS2);
    is_ts2  = (type_q == TYPE_TS2);
    lane_ok = (lane_q == {6'b0, lane_id});
`ifdef TS_CHECKSUM_EN
    chk_ok  = (rx_data == (type_q ^ lane_q ^ pay_q[31:24] ^ pay_q[23:16] ^
                           pay_q[15:8] ^ pay_q[7:0]));
`else
    chk_ok  = 1'b1;
`endif
    set_pass = type_ok && lane_ok && chk_ok;

    // A zero counter means no run is in progress, so the first set of any
    // type starts a new run at 1.
    if ((cons_q != '0) && (is_ts2 == ts_type)) begin
      if (cons_q == CNT_W'(CNT_MAX)) cons_next = cons_q;
      else                           cons_next = cons_q + CNT_W'(1);
    end else begin
      cons_next = CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_valid   <= 1'b0;
      ts_err     <= 1'b0;
      ts_type    <= 1'b0;
      ts_payload <= 32'h0;
      ts1_det    <= 1'b0;
      ts2_det    <= 1'b0;
      err_cnt    <= '0;
      cons_q     <= '0;
    end else begin
      ts_valid <= 1'b0;
      ts_err   <= 1'b0;
      if (!enable) begin
        // err_cnt deliberately survives a disable.
        cons_q  <= '0;
        ts1_det <= 1'b0;
        ts2_det <= 1'b0;
      end else if (set_done) begin
        if (set_pass) begin
          ts_valid   <= 1'b1;
          ts_type    <= is_ts2;
          ts_payload <= pay_q;
          cons_q     <= cons_next;
          if (!is_ts2 && (cons_next >= CNT_W'(TS1_REQ))) ts1_det <= 1'b1;
          if (is_ts2 && (cons_next >= CNT_W'(TS2_REQ)))  ts2_det <= 1'b1;
        end else begin
          ts_err <= 1'b1;
          cons_q <= '0;
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        end
      end
    end
  end

endmodule
